ts_rx_parse: RTL and testbench
==============================

# ts_rx_parse

Receive-side MPEG-2 transport stream parser for the test and monitor path: it consumes the byte stream of a TS source (sync / valid / data) and aligns to 188-byte packets. It extracts the header fields and the adaptation-field PCR, and flags sync, truncation and continuity-counter errors. It sits directly on a TS generator's output and provides per-packet status to scoreboards and PCR checkers.

## Interface
- PKT_LEN, 188, packet length in bytes; legal range 12..255.
- NULL_PID, 13'h1FFF, PID excluded from the continuity check.
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- ts_sync  in  1  high with the first byte (0x47) of a packet; only sampled when ts_valid=1.
- ts_valid  in  1  byte qualifier; ts_data is accepted on any clk edge where it is 1.
- ts_data  in  8  stream byte.
- hdr_valid  out  1  one-cycle pulse: pid/cc/afc/tei/pusi updated.
- tei, pusi  out  1 each  header flags.
- pid  out  13  packet PID.
- afc  out  2  adaptation_field_control.
- cc  out  4  continuity counter.
- pcr_valid  out  1  one-cycle pulse: pcr_base/pcr_ext updated.
- pcr_base  out  33  PCR base.
- pcr_ext  out  9  PCR extension.
- pkt_done  out  1  one-cycle pulse after the last byte of a complete packet.
- pkt_cnt  out  16  count of complete packets; wraps at 0xFFFF.
- sync_err  out  1  one-cycle pulse: bad sync byte or truncated packet.
- cc_err  out  1  one-cycle pulse: continuity discontinuity.
- cc_err_cnt  out  16  count of cc_err pulses; saturates at 0xFFFF.

## Operation
- Byte index idx is 8 bits, 0..PKT_LEN-1, and advances only on accepted bytes.
- States:
  - HUNT: accepted bytes without ts_sync are ignored. A byte with ts_sync and data 0x47 sets idx=1 and moves to HDR. A byte with ts_sync and data != 0x47 pulses sync_err and stays in HUNT.
  - HDR: byte 1 gives tei=[7], pusi=[6], pid[12:8]=[4:0]. Byte 2 gives pid[7:0]. Byte 3 gives afc=[5:4], cc=[3:0]. The edge after byte 3 pulses hdr_valid. If afc[1]=1 go to AF, else go to BODY.
  - AF: byte 4 is af_len. Byte 5 is flags and is captured only if af_len >= 1. The PCR path is taken only if af_len >= 7 and flags[4]=1; else go to BODY.
  - PCR: bytes 6..11 give pcr_base={b6,b7,b8,b9,b10[7]} and pcr_ext={b10[0],b11}. The edge after byte 11 pulses pcr_valid. Then go to BODY.
  - BODY: count bytes to idx=PKT_LEN-1. The edge after that byte pulses pkt_done, increments pkt_cnt, and returns to HUNT.
- A ts_sync byte accepted in any state other than HUNT truncates the packet:
  - pulse sync_err; no pkt_done for the truncated packet;
  - that byte is treated as a new packet start, with the same rules as HUNT, on the same edge.
- hdr_valid, pcr_valid, pkt_done, sync_err and cc_err are mutually independent; more than one may pulse on the same cycle.
- PCR byte registers are held unchanged between pcr_valid pulses; partial PCRs from truncated packets are never published.
- Reset values: every output is 0; state is HUNT; idx is 0; the last-PID tracker is invalid.

## Timing
- All outputs are registered; every pulse and field update appears on the clk edge after the edge that accepted the relevant byte.
- Throughput is one byte per cycle; any ts_valid gap pattern is legal and gives identical results.
- An assertion of rst mid-packet aborts parsing immediately; the first ts_sync byte after release is parsed normally.
- pid/cc/afc/tei/pusi are held until the next hdr_valid.

## Configuration
- TS_CC_CHECK_EN defined:
  - Tracker holds last_pid, last_cc and a valid bit.
  - On each header, if pid != NULL_PID, tracker is valid and pid == last_pid, the expected value is last_cc + afc[0] (mod 16). A mismatch pulses cc_err together with hdr_valid and increments cc_err_cnt.
  - The tracker is then loaded with the current pid/cc; NULL_PID headers do not load it.
- TS_CC_CHECK_EN undefined: tracker is absent, and cc_err and cc_err_cnt are constant 0.

## Test plan
- Single packet: pid 0x005, afc 2'b11, af_len 0x10, flags 0x10, PCR base 9, ext 9, valid every other cycle. Required: hdr_valid with pid=5 and cc as sent, pcr_valid with pcr_base=9 and pcr_ext=9, pkt_done after byte 187, pkt_cnt=1.
- First byte 0x46 with ts_sync: sync_err pulse, no hdr_valid, no pkt_done; the next good packet parses normally.
- ts_sync at idx 100: sync_err pulse, pkt_cnt unchanged; the new packet yields hdr_valid and pkt_done.
- TS_CC_CHECK_EN, pid 0x010, afc 2'b01, cc sequence 3,4,6: cc_err on the third packet only, cc_err_cnt=1. afc 2'b10 with repeated cc gives no error. pid 0x1FFF with random cc gives no error.
- af_len 5 with flags 0x10: no pcr_valid, and pcr_base/pcr_ext hold their previous values. PCR base 33'h1FFFFFFFF, ext 9'h1FF: read back exactly.
- rst asserted at idx 8 during AF: all outputs return to 0 immediately; a following packet gives hdr_valid and pkt_cnt=1.

Source files
------------

// File: rtl/ts_rx_if.sv
// Byte-stream link between a transport-stream source and the ts_rx_parse receiver.
interface ts_rx_if;
    logic       ts_sync;
    logic       ts_valid;
    logic [7:0] ts_data;

    modport master (output ts_sync, output ts_valid, output ts_data);
    modport slave  (input  ts_sync, input  ts_valid, input  ts_data);
endinterface

// File: rtl/ts_rx_parse.sv
// MPEG-2 TS receive parser: packet alignment, header/PCR extraction, sync and truncation errors.
// Define TS_CC_CHECK_EN to build the per-PID continuity-counter tracker (cc_err, cc_err_cnt).
module ts_rx_parse #(
    parameter int PKT_LEN = 188
`ifdef TS_CC_CHECK_EN
    ,
    parameter logic [12:0] NULL_PID = 13'h1FFF
`endif
) (
    input  logic        clk,
    input  logic        rst,
    ts_rx_if.slave      ts,
    output logic        hdr_valid,
    output logic        tei,
    output logic        pusi,
    output logic [12:0] pid,
    output logic [1:0]  afc,
    output logic [3:0]  cc,
    output logic        pcr_valid,
    output logic [32:0] pcr_base,
    output logic [8:0]  pcr_ext,
    output logic        pkt_done,
    output logic [15:0] pkt_cnt,
    output logic        sync_err,
    output logic        cc_err,
    output logic [15:0] cc_err_cnt
);

    localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);
    localparam logic [7:0] SYNC_BYTE = 8'h47;

    typedef enum logic [2:0] {HUNT, HDR, AF, PCR, BODY} state_t;

    state_t      state;
    logic [7:0]  idx;

    logic        tei_sh;
    logic        pusi_sh;
    logic [4:0]  pid_hi_sh;
    logic [7:0]  pid_lo_sh;
    logic [7:0]  af_len_r;
    logic [31:0] pcr_hi_sh;
    logic        pcr_b10_msb;
    logic        pcr_b10_lsb;

    logic        sop;
    logic        mid;
    logic        cap_b1;
    logic        cap_b2;
    logic        cap_af;
    logic        cap_pcr;
    logic        cap_b10;
    logic        pcr_go;
    logic [12:0] pid_new;

    // Byte classification: a synced byte always restarts, a plain byte advances the packet
    always_comb begin
        sop     = ts.ts_valid & ts.ts_sync;
        mid     = ts.ts_valid & ~ts.ts_sync;
        cap_b1  = mid && (state == HDR) && (idx == 8'd1);
        cap_b2  = mid && (state == HDR) && (idx == 8'd2);
        cap_af  = mid && (state == AF)  && (idx == 8'd4);
        cap_pcr = mid && (state == PCR) && (idx >= 8'd6) && (idx <= 8'd9);
        cap_b10 = mid && (state == PCR) && (idx == 8'd10);
        pcr_go  = (af_len_r >= 8'd7) && ts.ts_data[4];
        pid_new = {pid_hi_sh, pid_lo_sh};
    end

    // Staging registers: only published once the owning field is complete
    always_ff @(posedge clk) begin
        if (cap_b1) begin
            tei_sh    <= ts.ts_data[7];
            pusi_sh   <= ts.ts_data[6];
            pid_hi_sh <= ts.ts_data[4:0];
        end
        if (cap_b2)
            pid_lo_sh <= ts.ts_data;
        if (cap_af)
            af_len_r <= ts.ts_data;
        if (cap_pcr)
            pcr_hi_sh <= {pcr_hi_sh[23:0], ts.ts_data};
        if (cap_b10) begin
            pcr_b10_msb <= ts.ts_data[7];
            pcr_b10_lsb <= ts.ts_data[0];
        end
    end

`ifdef TS_CC_CHECK_EN
    logic [12:0] last_pid;
    logic [3:0]  last_cc;
    logic        trk_vld;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            idx        <= 8'd0;
            hdr_valid  <= 1'b0;
            tei        <= 1'b0;
            pusi       <= 1'b0;
            pid        <= 13'd0;
            afc        <= 2'd0;
            cc         <= 4'd0;
            pcr_valid  <= 1'b0;
            pcr_base   <= 33'd0;
            pcr_ext    <= 9'd0;
            pkt_done   <= 1'b0;
            pkt_cnt    <= 16'd0;
            sync_err   <= 1'b0;
`ifdef TS_CC_CHECK_EN
            cc_err     <= 1'b0;
            cc_err_cnt <= 16'd0;
            last_pid   <= 13'd0;
            last_cc    <= 4'd0;
            trk_vld    <= 1'b0;
`endif
        end else begin
            hdr_valid <= 1'b0;
            pcr_valid <= 1'b0;
            pkt_done  <= 1'b0;
            sync_err  <= 1'b0;
`ifdef TS_CC_CHECK_EN
            cc_err    <= 1'b0;
`endif
            if (sop) begin
                // Truncation and a bad sync byte share the one sync_err pulse
                sync_err <= (state != HUNT) || (ts.ts_data != SYNC_BYTE);
                if (ts.ts_data == SYNC_BYTE) begin
                    state <= HDR;
                    idx   <= 8'd1;
                end else begin
                    state <= HUNT;
                    idx   <= 8'd0;
                end
            end else if (mid && (state != HUNT)) begin
                idx <= idx + 8'd1;
                case (state)
                    HDR: begin
                        if (idx == 8'd3) begin
                            hdr_valid <= 1'b1;
                            tei       <= tei_sh;
                            pusi      <= pusi_sh;
                            pid       <= pid_new;
                            afc       <= ts.ts_data[5:4];
                            cc        <= ts.ts_data[3:0];
                            state     <= ts.ts_data[5] ? AF : BODY;
`ifdef TS_CC_CHECK_EN
                            if (pid_new != NULL_PID) begin
                                if (trk_vld && (pid_new == last_pid) &&
                                    (ts.ts_data[3:0] != last_cc + {3'b000, ts.ts_data[4]})) begin
                                    cc_err <= 1'b1;
                                    if (cc_err_cnt != 16'hFFFF)
                                        cc_err_cnt <= cc_err_cnt + 16'd1;
                                end
                                last_pid <= pid_new;
                                last_cc  <= ts.ts_data[3:0];
                                trk_vld  <= 1'b1;
                            end
`endif
                        end
                    end
                    AF: begin
                        if (idx == 8'd5)
                            state <= pcr_go ? PCR : BODY;
                    end
                    PCR: begin
                        if (idx == 8'd11) begin
                            pcr_valid <= 1'b1;
                            pcr_base  <= {pcr_hi_sh, pcr_b10_msb};
                            pcr_ext   <= {pcr_b10_lsb, ts.ts_data};
                            state     <= BODY;
                        end
                    end
                    default: ;
                endcase
                // The last byte ends the packet whatever section it falls in
                if (idx == LAST_IDX) begin
                    pkt_done <= 1'b1;
                    pkt_cnt  <= pkt_cnt + 16'd1;
                    state    <= HUNT;
                    idx      <= 8'd0;
                end
            end
        end
    end

`ifndef TS_CC_CHECK_EN
    assign cc_err     = 1'b0;
    assign cc_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ts_rx_parse.sv
// Directed bench for ts_rx_parse: header/PCR extraction, sync and truncation errors, CC check, reset abort.
module tb_ts_rx_parse;
    localparam int PKT_LEN = 188;
`ifdef TS_CC_CHECK_EN
    localparam int CC_EN = 1;
`else
    localparam int CC_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        hdr_valid, tei, pusi, pcr_valid, pkt_done, sync_err, cc_err;
    logic [12:0] pid;
    logic [1:0]  afc;
    logic [3:0]  cc;
    logic [32:0] pcr_base;
    logic [8:0]  pcr_ext;
    logic [15:0] pkt_cnt, cc_err_cnt;

    always #5 clk = ~clk;

    ts_rx_if ts ();

    ts_rx_parse #(.PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ts         (ts),
        .hdr_valid  (hdr_valid),
        .tei        (tei),
        .pusi       (pusi),
        .pid        (pid),
        .afc        (afc),
        .cc         (cc),
        .pcr_valid  (pcr_valid),
        .pcr_base   (pcr_base),
        .pcr_ext    (pcr_ext),
        .pkt_done   (pkt_done),
        .pkt_cnt    (pkt_cnt),
        .sync_err   (sync_err),
        .cc_err     (cc_err),
        .cc_err_cnt (cc_err_cnt)
    );

    int passed = 0, failed = 0, total = 0;
    int n_hdr = 0, n_pcr = 0, n_done = 0, n_serr = 0, n_cc = 0, n_cc_alone = 0;
    int b_hdr, b_pcr, b_done, b_serr, b_cc;
    bit gap;
    logic [7:0] pkt [0:PKT_LEN-1];

    // Pulse monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (hdr_valid) n_hdr++;
        if (pcr_valid) n_pcr++;
        if (pkt_done)  n_done++;
        if (sync_err)  n_serr++;
        if (cc_err)    n_cc++;
        if (cc_err && !hdr_valid) n_cc_alone++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_hdr = n_hdr; b_pcr = n_pcr; b_done = n_done; b_serr = n_serr; b_cc = n_cc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ts.ts_valid = 1'b0;
            ts.ts_sync  = 1'b1;
            ts.ts_data  = 8'h47;
            @(negedge clk);
        end
        ts.ts_sync = 1'b0;
    endtask

    task automatic put(input logic s, input logic [7:0] d);
        ts.ts_valid = 1'b1;
        ts.ts_sync  = s;
        ts.ts_data  = d;
        @(negedge clk);
        ts.ts_valid = 1'b0;
        ts.ts_sync  = 1'b0;
        if (gap) idle(1);
    endtask

    task automatic build(input logic [12:0] p, input logic [1:0] a, input logic [3:0] c,
                         input logic [7:0] af_len, input logic [7:0] flags,
                         input logic [32:0] base, input logic [8:0] ext);
        for (int i = 0; i < PKT_LEN; i++) pkt[i] = 8'(i) ^ 8'hA5;
        pkt[0] = 8'h47;
        pkt[1] = {3'b010, p[12:8]};
        pkt[2] = p[7:0];
        pkt[3] = {2'b00, a, c};
        if (a[1]) begin
            pkt[4]  = af_len;
            pkt[5]  = flags;
            pkt[6]  = base[32:25];
            pkt[7]  = base[24:17];
            pkt[8]  = base[16:9];
            pkt[9]  = base[8:1];
            pkt[10] = {base[0], 6'h3F, ext[8]};
            pkt[11] = ext[7:0];
        end
    endtask

    task automatic send(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) put(i == 0, pkt[i]);
    endtask

    task automatic send_cc(input logic [12:0] p, input logic [1:0] a, input logic [3:0] c);
        build(p, a, c, 8'h00, 8'h00, 33'd0, 9'd0);
        send(0, PKT_LEN - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; gap = 1'b0;
        ts.ts_valid = 1'b0; ts.ts_sync = 1'b0; ts.ts_data = 8'h00;
        idle(3);
        chk("rst_pulses", {59'd0, hdr_valid, pcr_valid, pkt_done, sync_err, cc_err}, 64'd0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_pid", {pid, afc, cc, tei, pusi}, 0);
        chk("rst_pcr", {pcr_base, pcr_ext}, 0);
        chk("rst_cc_err_cnt", cc_err_cnt, 0);
        rst = 1'b0;
        idle(2);

        // Single packet with PCR, one idle cycle between bytes
        gap = 1'b1;
        mark();
        build(13'h005, 2'b11, 4'h7, 8'h10, 8'h10, 33'd9, 9'd9);
        send(0, PKT_LEN - 2);
        chk("t1_no_early_done", n_done - b_done, 0);
        put(1'b0, pkt[PKT_LEN-1]);
        idle(2);
        chk("t1_hdr", n_hdr - b_hdr, 1);
        chk("t1_pid", pid, 13'h005);
        chk("t1_cc_afc", {afc, cc}, {2'b11, 4'h7});
        chk("t1_flags", {tei, pusi}, 2'b01);
        chk("t1_pcr_cnt", n_pcr - b_pcr, 1);
        chk("t1_pcr_base", pcr_base, 33'd9);
        chk("t1_pcr_ext", pcr_ext, 9'd9);
        chk("t1_done", n_done - b_done, 1);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_no_serr", n_serr - b_serr, 0);
        gap = 1'b0;

        // Bad sync byte, then a good packet
        mark();
        put(1'b1, 8'h46);
        idle(3);
        chk("t2_serr", n_serr - b_serr, 1);
        chk("t2_no_hdr", n_hdr - b_hdr, 0);
        chk("t2_no_done", n_done - b_done, 0);
        build(13'h020, 2'b01, 4'h0, 8'h00, 8'h00, 33'd0, 9'd0);
        send(0, PKT_LEN - 1);
        idle(2);
        chk("t2_hdr", n_hdr - b_hdr, 1);
        chk("t2_pid", pid, 13'h020);
        chk("t2_done", n_done - b_done, 1);
        chk("t2_pkt_cnt", pkt_cnt, 2);

        // Truncation: new sync at idx 100
        mark();
        build(13'h030, 2'b01, 4'h5, 8'h00, 8'h00, 33'd0, 9'd0);
        send(0, 99);
        build(13'h031, 2'b01, 4'h9, 8'h00, 8'h00, 33'd0, 9'd0);
        send(0, PKT_LEN - 2);
        chk("t3_serr", n_serr - b_serr, 1);
        chk("t3_cnt_held", pkt_cnt, 2);
        chk("t3_no_done", n_done - b_done, 0);
        put(1'b0, pkt[PKT_LEN-1]);
        idle(2);
        chk("t3_hdr", n_hdr - b_hdr, 2);
        chk("t3_pid_cc", {pid, cc}, {13'h031, 4'h9});
        chk("t3_done", n_done - b_done, 1);
        chk("t3_pkt_cnt", pkt_cnt, 3);

        // af_len 5: PCR flag set but field too short
        gap = 1'b1;
        mark();
        build(13'h040, 2'b11, 4'h2, 8'h05, 8'h10, 33'd123, 9'd45);
        send(0, PKT_LEN - 1);
        idle(2);
        gap = 1'b0;
        chk("t4_no_pcr", n_pcr - b_pcr, 0);
        chk("t4_pcr_held", {pcr_base, pcr_ext}, {33'd9, 9'd9});
        chk("t4_done", n_done - b_done, 1);

        // All-ones PCR with minimum af_len
        mark();
        build(13'h041, 2'b11, 4'h0, 8'h07, 8'h10, 33'h1FFFFFFFF, 9'h1FF);
        send(0, PKT_LEN - 1);
        idle(2);
        chk("t5_pcr_cnt", n_pcr - b_pcr, 1);
        chk("t5_pcr_base", pcr_base, 33'h1FFFFFFFF);
        chk("t5_pcr_ext", pcr_ext, 9'h1FF);
        chk("t5_pkt_cnt", pkt_cnt, 5);

        // Continuity: 3,4 good, 6 jumps
        mark();
        send_cc(13'h010, 2'b01, 4'd3);
        send_cc(13'h010, 2'b01, 4'd4);
        idle(2);
        chk("t6_no_err_yet", n_cc - b_cc, 0);
        send_cc(13'h010, 2'b01, 4'd6);
        idle(2);
        chk("t6_err", n_cc - b_cc, CC_EN);
        chk("t6_err_cnt", cc_err_cnt, CC_EN);
        // afc 10 repeats cc; null PID ignored and leaves the tracker alone
        send_cc(13'h010, 2'b10, 4'd6);
        send_cc(13'h010, 2'b10, 4'd6);
        send_cc(13'h1FFF, 2'b01, 4'd1);
        send_cc(13'h1FFF, 2'b01, 4'd9);
        send_cc(13'h1FFF, 2'b01, 4'd2);
        send_cc(13'h010, 2'b01, 4'd7);
        idle(2);
        chk("t6_err_total", n_cc - b_cc, CC_EN);
        chk("t6_err_cnt_final", cc_err_cnt, CC_EN);
        chk("t6_err_with_hdr", n_cc_alone, 0);
        chk("t6_hdr", n_hdr - b_hdr, 9);
        chk("t6_pkt_cnt", pkt_cnt, 14);

        // Reset in the middle of the adaptation field
        build(13'h050, 2'b11, 4'h1, 8'h10, 8'h10, 33'd77, 9'd3);
        send(0, 7);
        rst = 1'b1;
        #1;
        chk("t7_rst_pulses", {59'd0, hdr_valid, pcr_valid, pkt_done, sync_err, cc_err}, 64'd0);
        chk("t7_rst_pkt_cnt", pkt_cnt, 0);
        chk("t7_rst_fields", {pid, afc, cc, tei, pusi}, 0);
        chk("t7_rst_pcr", {pcr_base, pcr_ext}, 0);
        chk("t7_rst_cc_err_cnt", cc_err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        mark();
        build(13'h051, 2'b01, 4'h2, 8'h00, 8'h00, 33'd0, 9'd0);
        send(0, PKT_LEN - 1);
        idle(2);
        chk("t7_hdr", n_hdr - b_hdr, 1);
        chk("t7_pid", pid, 13'h051);
        chk("t7_pkt_cnt", pkt_cnt, 1);
        chk("t7_no_pcr", n_pcr - b_pcr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
